// File: rtl/cmd_proc.sv
// cmd_proc: command processor for the tour robot.
//   Takes one 16-bit command at a time ([15:12] opcode, [11:4] heading, [3:0] squares).
//   It starts gyro calibration, turns to a heading, and ramps forward speed up and down
//   across 2*squares board lines. It also fires the tour-solve and fanfare pulses.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_cmd, i_cmd_rdy          command word and its level-valid flag
//   o_clr_cmd_rdy             pulse: command taken
//   o_send_resp               pulse: command complete
//   o_strt_cal, i_cal_done    calibration handshake
//   i_heading, i_heading_rdy  gyro heading (signed) and sample strobe
//   i_lftIR, i_rghtIR         side-rail guard sensors (heading nudge)
//   i_cntrIR                  center line sensor
//   o_frwrd, o_error          forward speed and heading error to the PID
//   o_moving                  high while turning or ramping
//   o_tour_go, o_fanfare_go   pulses: start tour solve, play fanfare
module cmd_proc #(
  parameter int FAST_SIM = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cmd,
  input  logic        i_cmd_rdy,
  input  logic        i_cal_done,
  input  logic [11:0] i_heading,
  input  logic        i_heading_rdy,
  input  logic        i_lftIR,
  input  logic        i_rghtIR,
  input  logic        i_cntrIR,
  output logic        o_clr_cmd_rdy,
  output logic        o_send_resp,
  output logic        o_strt_cal,
  output logic [9:0]  o_frwrd,
  output logic [11:0] o_error,
  output logic        o_moving,
  output logic        o_tour_go,
  output logic        o_fanfare_go
);

  localparam logic [11:0] NUDGE     = (FAST_SIM != 0) ? 12'h1FF : 12'h05F;
  localparam logic [9:0]  INC       = (FAST_SIM != 0) ? 10'd32  : 10'd1;
  localparam logic [9:0]  DEC       = INC << 1;
  localparam logic [9:0]  FRWRD_MAX = 10'h2A0;
  localparam logic [11:0] TURN_TOL  = 12'h02C;

  typedef enum logic [2:0] {S_IDLE, S_CAL, S_TURN, S_RAMP_UP, S_RAMP_DOWN} state_t;

  state_t      r_state, w_nxt;
  logic [3:0]  r_op;
  logic [11:0] r_desired;
  logic [3:0]  r_squares;
  logic        r_fanfare;
  logic [9:0]  r_frwrd;
  logic [4:0]  r_line_cnt;
  logic        r_cntr_q;

  logic        w_accept;
  logic        w_turn_cmd;
  logic        w_moving;
  logic        w_done;
  logic        w_line_rise;
  logic [11:0] w_nudge;
  logic [11:0] w_error;
  logic [11:0] w_err_abs;
  logic [10:0] w_up_sum;

  assign w_accept    = (r_state == S_IDLE) && i_cmd_rdy;
  assign w_turn_cmd  = (i_cmd[15:12] == 4'b0010) || (i_cmd[15:12] == 4'b0011);
  assign w_moving    = (r_state == S_TURN) || (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
  assign w_done      = (r_state == S_RAMP_DOWN) && (r_frwrd == 10'd0);
  assign w_line_rise = i_cntrIR && !r_cntr_q;

  // Left rail wins when both guards see the rail.
  always_comb begin
    w_nudge = 12'h000;
    if (w_moving) begin
      if (i_lftIR)       w_nudge = NUDGE;
      else if (i_rghtIR) w_nudge = 12'h000 - NUDGE;
    end
  end

  assign w_error   = i_heading - r_desired + w_nudge;
  // 12'h800 has no positive twin; it stays 12'h800, which is still out of tolerance.
  assign w_err_abs = w_error[11] ? (12'h000 - w_error) : w_error;
  assign w_up_sum  = {1'b0, r_frwrd} + {1'b0, INC};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_rdy) begin
          if (i_cmd[15:12] == 4'b0000) w_nxt = S_CAL;
          else if (w_turn_cmd)         w_nxt = S_TURN;
        end
      end
      S_CAL:       if (i_cal_done) w_nxt = S_IDLE;
      S_TURN:      if (w_err_abs < TURN_TOL) w_nxt = S_RAMP_UP;
      S_RAMP_UP:   if (r_line_cnt == {r_squares, 1'b0}) w_nxt = S_RAMP_DOWN;
      S_RAMP_DOWN: if (r_frwrd == 10'd0) w_nxt = S_IDLE;
      default:     w_nxt = S_IDLE;
    endcase
  end

  // Output logic. Pulses are held off during the reset cycle so nothing fires while rst is high.
  always_comb begin
    o_clr_cmd_rdy = 1'b0;
    o_strt_cal    = 1'b0;
    o_tour_go     = 1'b0;
    o_send_resp   = 1'b0;
    o_fanfare_go  = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_IDLE: begin
          o_clr_cmd_rdy = i_cmd_rdy;
          o_strt_cal    = i_cmd_rdy && (i_cmd[15:12] == 4'b0000);
          o_tour_go     = i_cmd_rdy && (i_cmd[15:12] == 4'b0100);
        end
        S_CAL:       o_send_resp = i_cal_done;
        S_RAMP_DOWN: begin
          o_send_resp  = w_done;
          o_fanfare_go = w_done && r_fanfare && (r_op == 4'b0011);
        end
        default: ;
      endcase
    end
  end

  assign o_moving = w_moving;
  assign o_frwrd  = r_frwrd;
  assign o_error  = w_error;

  // Command capture, line counting and speed ramp
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op       <= 4'h0;
      r_desired  <= 12'h000;
      r_squares  <= 4'h0;
      r_fanfare  <= 1'b0;
      r_frwrd    <= 10'd0;
      r_line_cnt <= 5'd0;
      r_cntr_q   <= 1'b0;
    end else begin
      r_cntr_q <= i_cntrIR;

      if (w_accept) begin
        r_op      <= i_cmd[15:12];
        r_desired <= (i_cmd[11:4] == 8'h00) ? 12'h000 : {i_cmd[11:4], 4'hF};
        r_squares <= i_cmd[3:0];
      end

      // A new turn command restarts the line count; this takes priority over an edge.
      if (w_accept && w_turn_cmd) begin
        r_fanfare  <= (i_cmd[15:12] == 4'b0011);
        r_line_cnt <= 5'd0;
      end else if (w_line_rise && (r_line_cnt != 5'd31)) begin
        r_line_cnt <= r_line_cnt + 5'd1;
      end

      // Ramp rule is chosen by the current state, even on a transition cycle.
      case (r_state)
        S_TURN: r_frwrd <= 10'd0;
        S_RAMP_UP: begin
          if (i_heading_rdy)
            r_frwrd <= (w_up_sum >= {1'b0, FRWRD_MAX}) ? FRWRD_MAX : w_up_sum[9:0];
        end
        S_RAMP_DOWN: begin
          if (i_heading_rdy)
            r_frwrd <= (r_frwrd > DEC) ? (r_frwrd - DEC) : 10'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_proc.sv
// tb_cmd_proc: directed bench for cmd_proc. A normal-speed and a FAST_SIM instance share
// all inputs; each task checks its own outputs inline.
module tb_cmd_proc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cmd = 16'h0;
  logic        cmd_rdy = 1'b0, cal_done = 1'b0, hrdy = 1'b0;
  logic [11:0] heading = 12'h0;
  logic        lft = 1'b0, rght = 1'b0, cntr = 1'b0;

  logic        clr, resp, cal, mov, tour, fan;
  logic [9:0]  frwrd;
  logic [11:0] err;
  logic        f_clr, f_resp, f_cal, f_mov, f_tour, f_fan;
  logic [9:0]  f_frwrd;
  logic [11:0] f_err;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  cmd_proc #(.FAST_SIM(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_cmd(cmd), .i_cmd_rdy(cmd_rdy), .i_cal_done(cal_done),
    .i_heading(heading), .i_heading_rdy(hrdy), .i_lftIR(lft), .i_rghtIR(rght), .i_cntrIR(cntr),
    .o_clr_cmd_rdy(clr), .o_send_resp(resp), .o_strt_cal(cal), .o_frwrd(frwrd),
    .o_error(err), .o_moving(mov), .o_tour_go(tour), .o_fanfare_go(fan));

  cmd_proc #(.FAST_SIM(1)) u_fast (
    .i_clk(clk), .i_rst(rst), .i_cmd(cmd), .i_cmd_rdy(cmd_rdy), .i_cal_done(cal_done),
    .i_heading(heading), .i_heading_rdy(hrdy), .i_lftIR(lft), .i_rghtIR(rght), .i_cntrIR(cntr),
    .o_clr_cmd_rdy(f_clr), .o_send_resp(f_resp), .o_strt_cal(f_cal), .o_frwrd(f_frwrd),
    .o_error(f_err), .o_moving(f_mov), .o_tour_go(f_tour), .o_fanfare_go(f_fan));

  task automatic tick; @(posedge clk); #1; endtask
  task automatic mid;  @(negedge clk);     endtask

  task automatic do_reset;
    cmd_rdy = 0; hrdy = 0; cntr = 0; lft = 0; rght = 0; cal_done = 0;
    rst = 1; tick; rst = 0;
  endtask

  task automatic test_reset;
    heading = 12'h123; cmd_rdy = 0; hrdy = 0; cntr = 0; lft = 0; rght = 0; cal_done = 0;
    rst = 1; tick; rst = 0; mid;
    total++; if ({clr, resp, cal, tour, fan, mov} !== 6'b0) begin bad++; $display("FAIL rst_outs: got %b want 000000", {clr, resp, cal, tour, fan, mov}); end
    total++; if (frwrd !== 10'd0) begin bad++; $display("FAIL rst_frwrd: got %h want 000", frwrd); end
    total++; if (err !== 12'h123) begin bad++; $display("FAIL rst_err: got %h want 123", err); end
    total++; if (f_frwrd !== 10'd0) begin bad++; $display("FAIL rst_ffrwrd: got %h want 000", f_frwrd); end
  endtask

  task automatic test_cal;
    do_reset;
    cmd = 16'h0000; cmd_rdy = 1; mid;
    total++; if ({clr, cal, resp, mov} !== 4'b1100) begin bad++; $display("FAIL cal_accept: got %b want 1100", {clr, cal, resp, mov}); end
    tick; cmd_rdy = 0; mid;
    total++; if ({clr, cal, resp, mov} !== 4'b0000) begin bad++; $display("FAIL cal_wait: got %b want 0000", {clr, cal, resp, mov}); end
    tick; tick; cal_done = 1; mid;
    total++; if ({resp, mov} !== 2'b10) begin bad++; $display("FAIL cal_resp: got %b want 10", {resp, mov}); end
    tick; cal_done = 0; mid;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL cal_resp_pulse: got %b want 0", resp); end
    cmd = 16'h4000; cmd_rdy = 1; mid;
    total++; if ({clr, tour} !== 2'b11) begin bad++; $display("FAIL cal_back_idle: got %b want 11", {clr, tour}); end
    tick; cmd_rdy = 0;
  endtask

  task automatic test_opcodes;
    do_reset;
    cmd = 16'h4000; cmd_rdy = 1; mid;
    total++; if ({clr, tour, resp, cal, mov} !== 5'b11000) begin bad++; $display("FAIL tour: got %b want 11000", {clr, tour, resp, cal, mov}); end
    tick; cmd = 16'h7123; mid;
    total++; if ({clr, tour, resp, cal, mov} !== 5'b10000) begin bad++; $display("FAIL bad_op: got %b want 10000", {clr, tour, resp, cal, mov}); end
    tick; cmd_rdy = 0; mid;
    total++; if ({clr, mov} !== 2'b00) begin bad++; $display("FAIL bad_op_idle: got %b want 00", {clr, mov}); end
  endtask

  task automatic test_move;
    do_reset;
    heading = 12'h000; cmd = 16'h2002; cmd_rdy = 1; mid;
    total++; if ({clr, mov} !== 2'b10) begin bad++; $display("FAIL mv_accept: got %b want 10", {clr, mov}); end
    tick; cmd_rdy = 0; hrdy = 1; mid;
    total++; if ({mov, frwrd, err} !== {1'b1, 10'd0, 12'h000}) begin bad++; $display("FAIL mv_turn: got %b %h %h want 1 000 000", mov, frwrd, err); end
    tick; mid;
    total++; if (frwrd !== 10'd0) begin bad++; $display("FAIL mv_turn_hrdy: got %h want 000", frwrd); end
    repeat (5) tick;
    hrdy = 0; mid;
    total++; if (frwrd !== 10'd5) begin bad++; $display("FAIL mv_ramp5: got %0d want 5", frwrd); end
    repeat (3) begin cntr = 1; tick; cntr = 0; tick; end
    hrdy = 1; tick; hrdy = 0; mid;
    total++; if (frwrd !== 10'd6) begin bad++; $display("FAIL mv_still_up: got %0d want 6", frwrd); end
    cntr = 1; tick; cntr = 0; tick;
    hrdy = 1; tick; mid;
    total++; if (frwrd !== 10'd4) begin bad++; $display("FAIL mv_down: got %0d want 4", frwrd); end
    tick; tick; hrdy = 0; mid;
    total++; if ({frwrd, resp, fan, mov} !== {10'd0, 3'b101}) begin bad++; $display("FAIL mv_done: got %h %b%b%b want 000 101", frwrd, resp, fan, mov); end
    tick; mid;
    total++; if ({resp, mov} !== 2'b00) begin bad++; $display("FAIL mv_idle: got %b want 00", {resp, mov}); end
  endtask

  task automatic test_fanfare;
    do_reset;
    heading = 12'h3FF; cmd = 16'h33F1; cmd_rdy = 1; tick; cmd_rdy = 0; mid;
    total++; if ({err, mov} !== {12'h000, 1'b1}) begin bad++; $display("FAIL ff_turn: got %h %b want 000 1", err, mov); end
    tick; hrdy = 1; repeat (3) tick; hrdy = 0; mid;
    total++; if (frwrd !== 10'd3) begin bad++; $display("FAIL ff_ramp: got %0d want 3", frwrd); end
    repeat (2) begin cntr = 1; tick; cntr = 0; tick; end
    hrdy = 1; tick; mid;
    total++; if (frwrd !== 10'd1) begin bad++; $display("FAIL ff_down: got %0d want 1", frwrd); end
    tick; hrdy = 0; mid;
    total++; if ({frwrd, resp, fan} !== {10'd0, 2'b11}) begin bad++; $display("FAIL ff_done: got %h %b%b want 000 11", frwrd, resp, fan); end
    tick; mid;
    total++; if ({resp, fan, mov} !== 3'b000) begin bad++; $display("FAIL ff_pulse: got %b want 000", {resp, fan, mov}); end
  endtask

  task automatic test_turn_tol;
    do_reset;
    heading = 12'h02C; cmd = 16'h2000; cmd_rdy = 1; tick; cmd_rdy = 0; hrdy = 1;
    tick; tick; mid;
    total++; if ({mov, frwrd} !== {1'b1, 10'd0}) begin bad++; $display("FAIL tol_pos: got %b %h want 1 000", mov, frwrd); end
    heading = 12'hFD4; tick; tick; mid;
    total++; if (frwrd !== 10'd0) begin bad++; $display("FAIL tol_neg: got %h want 000", frwrd); end
    heading = 12'hFD5; tick; mid;
    total++; if (frwrd !== 10'd0) begin bad++; $display("FAIL tol_enter: got %h want 000", frwrd); end
    tick; mid;
    total++; if ({frwrd, resp} !== {10'd1, 1'b0}) begin bad++; $display("FAIL sq0_up: got %h %b want 001 0", frwrd, resp); end
    tick; mid;
    total++; if ({frwrd, resp} !== {10'd0, 1'b1}) begin bad++; $display("FAIL sq0_done: got %h %b want 000 1", frwrd, resp); end
    hrdy = 0; tick; mid;
    total++; if (mov !== 1'b0) begin bad++; $display("FAIL sq0_idle: got %b want 0", mov); end
  endtask

  task automatic test_fast;
    do_reset;
    heading = 12'h000; lft = 1; mid;
    total++; if ({err, f_err} !== 24'h000000) begin bad++; $display("FAIL nudge_idle: got %h %h want 000 000", err, f_err); end
    lft = 0; cmd = 16'h2005; cmd_rdy = 1; tick; cmd_rdy = 0; tick;
    hrdy = 1; repeat (20) tick; mid;
    total++; if (f_frwrd !== 10'h280) begin bad++; $display("FAIL fast_ramp20: got %h want 280", f_frwrd); end
    repeat (10) tick;
    hrdy = 0; mid;
    total++; if (f_frwrd !== 10'h2A0) begin bad++; $display("FAIL fast_sat: got %h want 2a0", f_frwrd); end
    total++; if (frwrd !== 10'd30) begin bad++; $display("FAIL slow_ramp30: got %0d want 30", frwrd); end
    lft = 1; mid;
    total++; if ({f_err, err} !== {12'h1FF, 12'h05F}) begin bad++; $display("FAIL nudge_lft: got %h %h want 1ff 05f", f_err, err); end
    rght = 1; mid;
    total++; if ({f_err, err} !== {12'h1FF, 12'h05F}) begin bad++; $display("FAIL nudge_both: got %h %h want 1ff 05f", f_err, err); end
    lft = 0; mid;
    total++; if ({f_err, err} !== {12'hE01, 12'hFA1}) begin bad++; $display("FAIL nudge_rght: got %h %h want e01 fa1", f_err, err); end
    rght = 0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    heading = 12'h000; cmd = 16'h2005; cmd_rdy = 1; tick; cmd_rdy = 0; tick;
    hrdy = 1; repeat (8) tick; hrdy = 0; mid;
    total++; if ({f_frwrd, f_mov} !== {10'h100, 1'b1}) begin bad++; $display("FAIL rm_pre: got %h %b want 100 1", f_frwrd, f_mov); end
    heading = 12'h0A5; lft = 1; rst = 1; tick; rst = 0; mid;
    total++; if ({f_frwrd, f_mov, frwrd, mov} !== 22'd0) begin bad++; $display("FAIL rm_clear: got %h %b %h %b want 000 0 000 0", f_frwrd, f_mov, frwrd, mov); end
    total++; if ({err, f_err} !== 24'h0A50A5) begin bad++; $display("FAIL rm_err: got %h %h want 0a5 0a5", err, f_err); end
    total++; if ({clr, resp, cal, tour, fan} !== 5'b0) begin bad++; $display("FAIL rm_pulses: got %b want 00000", {clr, resp, cal, tour, fan}); end
    lft = 0; cmd = 16'h0000; cmd_rdy = 1; #1;
    total++; if ({clr, cal, f_clr, f_cal} !== 4'b1111) begin bad++; $display("FAIL rm_new_cmd: got %b want 1111", {clr, cal, f_clr, f_cal}); end
    tick; cmd_rdy = 0; cal_done = 1; tick; cal_done = 0;
  endtask

  task automatic test_back_to_back;
    do_reset;
    heading = 12'h000; cmd = 16'h2001; cmd_rdy = 1; tick; cmd_rdy = 0; tick;
    cmd = 16'h0000; cmd_rdy = 1; hrdy = 1; tick; tick; hrdy = 0; mid;
    total++; if ({clr, frwrd} !== {1'b0, 10'd2}) begin bad++; $display("FAIL b2b_up: got %b %0d want 0 2", clr, frwrd); end
    repeat (2) begin cntr = 1; tick; cntr = 0; tick; end
    mid;
    total++; if ({clr, mov} !== 2'b01) begin bad++; $display("FAIL b2b_down: got %b want 01", {clr, mov}); end
    hrdy = 1; tick; hrdy = 0; mid;
    total++; if ({frwrd, resp, clr} !== {10'd0, 2'b10}) begin bad++; $display("FAIL b2b_resp: got %h %b%b want 000 10", frwrd, resp, clr); end
    tick; mid;
    total++; if ({clr, cal, resp} !== 3'b110) begin bad++; $display("FAIL b2b_accept: got %b want 110", {clr, cal, resp}); end
    tick; cmd_rdy = 0; mid;
    total++; if ({clr, mov} !== 2'b00) begin bad++; $display("FAIL b2b_cal: got %b want 00", {clr, mov}); end
    cal_done = 1; tick; cal_done = 0;
  endtask

  initial begin
    test_reset;
    test_cal;
    test_opcodes;
    test_move;
    test_fanfare;
    test_turn_tol;
    test_fast;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_proc.md
CMD_PROC -- requirements
Module: cmd_proc

Interface
REQ-001 Parameter: FAST_SIM, default 0, nonzero selects accelerated ramp and nudge constants for simulation.
REQ-002 clk  input  1  system clock, 50MHz; all state changes on posedge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 cmd  input  16  command: [15:12] opcode, [11:4] heading, [3:0] squares.
REQ-005 cmd_rdy  input  1  cmd valid; level, held until clr_cmd_rdy.
REQ-006 clr_cmd_rdy  output  1  one-cycle pulse, command accepted.
REQ-007 send_resp  output  1  one-cycle pulse, command complete.
REQ-008 strt_cal  output  1  one-cycle pulse, start gyro calibration.
REQ-009 cal_done  input  1  calibration finished.
REQ-010 heading  input  12  current gyro heading, signed.
REQ-011 heading_rdy  input  1  one-cycle strobe, new heading sample.
REQ-012 lftIR, rghtIR  input  1 each  side-rail guard sensors.
REQ-013 cntrIR  input  1  center line sensor, high over a board line.
REQ-014 frwrd  output  10  forward speed to PID.
REQ-015 error  output  12  heading error to PID.
REQ-016 moving  output  1  high in TURN, RAMP_UP, RAMP_DOWN.
REQ-017 tour_go  output  1  one-cycle pulse, start tour solve.
REQ-018 fanfare_go  output  1  one-cycle pulse, play fanfare.

Function
REQ-019 States: IDLE, CAL, TURN, RAMP_UP, RAMP_DOWN; reset state IDLE.
REQ-020 IDLE + cmd_rdy: clr_cmd_rdy pulses that same cycle; cmd registered into op, desired, squares.
REQ-021 Opcode 4'b0000: strt_cal pulse -> CAL.
REQ-022 Opcode 4'b0010 or 4'b0011: line counter cleared -> TURN; fanfare flag latched = (op==4'b0011).
REQ-023 Opcode 4'b0100: tour_go pulse, stay IDLE, no send_resp.
REQ-024 Other opcodes: clr_cmd_rdy only, command discarded, stay IDLE.
REQ-025 cmd_rdy outside IDLE: ignored, no clr_cmd_rdy.
REQ-026 CAL: on cal_done -> send_resp pulse, IDLE.
REQ-027 desired_heading = 12'h000 when cmd[11:4]==0, else {cmd[11:4],4'hF}.
REQ-028 error = heading - desired_heading + nudge, 12-bit modulo.
REQ-029 nudge: lftIR -> +NUDGE; else rghtIR -> -NUDGE; else 0; applied only while moving; NUDGE = 12'h05F (FAST_SIM: 12'h1FF).
REQ-030 TURN: frwrd held 0; |error| < 12'h02C (signed magnitude) -> RAMP_UP.
REQ-031 RAMP_UP: each heading_rdy adds INC to frwrd, INC = 1 (FAST_SIM: 32), saturating at 10'h2A0.
REQ-032 Lines: cntrIR registered; each 0->1 edge increments a 5-bit counter; counter saturates at 31.
REQ-033 RAMP_UP -> RAMP_DOWN when count == 2*squares; squares==0 enters RAMP_DOWN on the first RAMP_UP cycle.
REQ-034 RAMP_DOWN: each heading_rdy subtracts 2*INC, floor 0, no underflow; line edges still counted.
REQ-035 RAMP_DOWN with frwrd==0 -> send_resp pulse, fanfare_go pulse same cycle if fanfare flag set, -> IDLE.
REQ-036 At most one command in flight: send_resp strictly follows its clr_cmd_rdy, at least 1 cycle later.
REQ-037 heading_rdy coinciding with a state transition applies the ramp rule of the current state only.

Reset
REQ-038 rst at any cycle, mid-move included: IDLE; frwrd=0; line count=0; op, desired, squares, fanfare flag = 0; every pulse output and moving = 0 the next cycle.
REQ-039 error remains combinational; post-reset value = heading - 12'h000.

Verification
REQ-040 cmd=16'h0000, cmd_rdy -> clr_cmd_rdy 1 cycle, strt_cal 1 cycle; cal_done -> send_resp 1 cycle, IDLE.
REQ-041 cmd=16'h2002, heading=12'h000 -> TURN, RAMP_UP; 4 cntrIR edges -> RAMP_DOWN; frwrd reaches 0 -> send_resp, fanfare_go stays 0.
REQ-042 cmd=16'h33F1, heading=12'h3FF -> 2 edges, send_resp and fanfare_go pulsed in the same cycle.
REQ-043 FAST_SIM=1, 30 heading_rdy strobes in RAMP_UP -> frwrd saturates at 10'h2A0; lftIR=1 -> error += 12'h1FF.
REQ-044 rst asserted with frwrd=10'h100 in RAMP_UP -> next cycle IDLE, frwrd=0, moving=0; new cmd accepted normally.
REQ-045 Second cmd_rdy during RAMP_UP -> no clr_cmd_rdy until after send_resp; then accepted from IDLE.
